// File: rtl/mux_pkg.sv
// Package: mux_pkg
// Purpose: shared types and defaults for the round-robin mux feeder.
//   own_state_t   - arbitration ownership state (IDLE, OWN0, OWN1)
//   DEFAULT_WIDTH - default data width of the feeder and its output slice
//   DEFAULT_BURST - default number of consecutive beats one owner may take
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } own_state_t;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_BURST = 4;

endpackage

// File: rtl/out_reg_slice.sv
// Module: out_reg_slice
// Purpose: one-entry output register holding the chosen beat, its source
//          index and a valid flag.
// Ports:
//   clk    in   1      clock
//   rst    in   1      synchronous active-high reset
//   load   in   1      capture din/sin this cycle
//   drain  in   1      downstream consumes the held beat this cycle
//   din    in   WIDTH  beat to capture
//   sin    in   1      source index of the beat to capture
//   y      out  WIDTH  held beat
//   s      out  1      held source index
//   y_vld  out  1      held beat is valid
module out_reg_slice
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] y,
  output logic             s,
  output logic             y_vld
);

  // A load wins over a drain: the new beat replaces the consumed one and
  // the valid flag stays set. A drain alone only clears the valid flag so
  // y and s keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      s     <= 1'b0;
      y_vld <= 1'b0;
    end else if (load) begin
      y     <= din;
      s     <= sin;
      y_vld <= 1'b1;
    end else if (drain) begin
      y_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_rr_feeder.sv
// Module: mux_rr_feeder
// Purpose: two-source round-robin arbiter with burst lock feeding a
//          one-entry output register (mux select s and data beat y).
// Ports:
//   clk    in   1      clock
//   rst    in   1      synchronous active-high reset
//   req0   in   1      source 0 has a beat on d0
//   d0     in   WIDTH  source 0 data
//   req1   in   1      source 1 has a beat on d1
//   d1     in   WIDTH  source 1 data
//   gnt0   out  1      beat on d0 accepted this cycle (combinational)
//   gnt1   out  1      beat on d1 accepted this cycle (combinational)
//   s      out  1      registered source index of the beat in y
//   y      out  WIDTH  registered data beat
//   y_vld  out  1      y holds a valid beat
//   y_rdy  in   1      downstream consumes y this cycle when y_vld=1
module mux_rr_feeder
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BURST = DEFAULT_BURST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_vld,
  input  logic             y_rdy
);

  localparam int CW = $clog2(BURST + 1);

  own_state_t      state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            last;
  logic            sel;
  logic            can_load;
  logic            grant_any;
  logic            gnt_src;
  logic            same_owner;

  assign can_load = ~y_vld | y_rdy;

  // Burst lock keeps the current owner while it still requests and has
  // beats left; otherwise a tie goes to the source that did not win last.
  always_comb begin
    sel = 1'b0;
    if (state == OWN0 && req0 && cnt < CW'(BURST)) begin
      sel = 1'b0;
    end else if (state == OWN1 && req1 && cnt < CW'(BURST)) begin
      sel = 1'b1;
    end else if (req0 && req1) begin
      sel = ~last;
    end else begin
      sel = req1;
    end
  end

  assign gnt0      = ~rst & can_load & req0 & ~sel;
  assign gnt1      = ~rst & can_load & req1 &  sel;
  assign grant_any = gnt0 | gnt1;
  assign gnt_src   = gnt1;

  assign same_owner = (state == OWN0 && !gnt_src) || (state == OWN1 && gnt_src);

  always_comb begin
    cnt_next = CW'(1);
    if (same_owner) begin
      cnt_next = cnt + CW'(1);
    end
  end

  // Ownership FSM. Reaching the burst limit drops straight to IDLE so the
  // tie-break (last) hands the next contested beat to the other source.
  // An owner that stops requesting is released only on a cycle where a
  // beat could have been taken, so backpressure never changes ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else if (grant_any) begin
      last <= gnt_src;
      cnt  <= cnt_next;
      if (cnt_next == CW'(BURST)) begin
        state <= IDLE;
      end else begin
        state <= gnt_src ? OWN1 : OWN0;
      end
    end else if (can_load) begin
      if ((state == OWN0 && !req0) || (state == OWN1 && !req1)) begin
        state <= IDLE;
      end
    end
  end

  out_reg_slice #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk  (clk),
    .rst  (rst),
    .load (grant_any),
    .drain(y_vld & y_rdy),
    .din  (gnt_src ? d1 : d0),
    .sin  (gnt_src),
    .y    (y),
    .s    (s),
    .y_vld(y_vld)
  );

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Testbench: tb_mux_rr_feeder
// Purpose: directed self-checking bench for mux_rr_feeder. Two instances
//          share the stimulus: dut4 (BURST=4) and dut1 (BURST=1).
module tb_mux_rr_feeder;

  localparam int W = 4;
  localparam logic [W-1:0] DA = 4'hA;
  localparam logic [W-1:0] D5 = 4'h5;

  logic         clk;
  logic         rst;
  logic         req0, req1, y_rdy;
  logic [W-1:0] d0, d1;

  logic         gnt0_4, gnt1_4, s_4, vld_4;
  logic [W-1:0] y_4;
  logic         gnt0_1, gnt1_1, s_1, vld_1;
  logic [W-1:0] y_1;

  int checks = 0;
  int errors = 0;

  mux_rr_feeder #(.WIDTH(W), .BURST(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .gnt0(gnt0_4), .gnt1(gnt1_4),
    .s(s_4), .y(y_4), .y_vld(vld_4), .y_rdy(y_rdy)
  );

  mux_rr_feeder #(.WIDTH(W), .BURST(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .gnt0(gnt0_1), .gnt1(gnt1_1),
    .s(s_1), .y(y_1), .y_vld(vld_1), .y_rdy(y_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive all source/sink inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic r0, input logic [W-1:0] v0,
                               input logic r1, input logic [W-1:0] v1,
                               input logic rdy);
    req0  = r0;
    d0    = v0;
    req1  = r1;
    d1    = v1;
    y_rdy = rdy;
    #1;
  endtask

  // Advance past the next rising edge so registered outputs can be sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    logic exp_s;
    rst = 1'b1;

    // Reset held with both sources requesting.
    applyStimulus(1'b1, DA, 1'b1, D5, 1'b1);
    checkOutput("rst_gnt0_pre", 32'(gnt0_4), 32'd0);
    doReset();
    checkOutput("rst_gnt0", 32'(gnt0_4), 32'd0);
    checkOutput("rst_gnt1", 32'(gnt1_4), 32'd0);
    checkOutput("rst_vld",  32'(vld_4),  32'd0);
    checkOutput("rst_y",    32'(y_4),    32'd0);
    checkOutput("rst_s",    32'(s_4),    32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, DA, 1'b1, D5, 1'b1);
    checkOutput("first_gnt0", 32'(gnt0_4), 32'd1);
    checkOutput("first_gnt1", 32'(gnt1_4), 32'd0);

    // Fairness: BURST=4 gives 0,0,0,0,1,1,1,1,0; BURST=1 alternates.
    for (int i = 0; i < 9; i++) begin
      exp_s = (i >= 4 && i < 8);
      checkOutput($sformatf("fair4_gnt1_%0d", i), 32'(gnt1_4), 32'(exp_s));
      checkOutput($sformatf("fair1_gnt1_%0d", i), 32'(gnt1_1), 32'(i % 2));
      tick();
      checkOutput($sformatf("fair4_s_%0d", i), 32'(s_4), 32'(exp_s));
      checkOutput($sformatf("fair4_y_%0d", i), 32'(y_4), exp_s ? 32'(D5) : 32'(DA));
      checkOutput($sformatf("fair1_s_%0d", i), 32'(s_1), 32'(i % 2));
    end

    // Backpressure: dut4 is OWN0 with cnt=1 holding DA.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, DA, 1'b1, D5, 1'b0);
      checkOutput($sformatf("bp_gnt0_%0d", i), 32'(gnt0_4), 32'd0);
      checkOutput($sformatf("bp_gnt1_%0d", i), 32'(gnt1_4), 32'd0);
      tick();
      checkOutput($sformatf("bp_y_%0d", i),   32'(y_4),   32'(DA));
      checkOutput($sformatf("bp_s_%0d", i),   32'(s_4),   32'd0);
      checkOutput($sformatf("bp_vld_%0d", i), 32'(vld_4), 32'd1);
    end
    // Burst resumes at cnt=1: three more source-0 beats, then source 1.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, DA, 1'b1, D5, 1'b1);
      checkOutput($sformatf("bp_resume_gnt0_%0d", i), 32'(gnt0_4), 32'(i < 3));
      checkOutput($sformatf("bp_resume_gnt1_%0d", i), 32'(gnt1_4), 32'(i == 3));
      tick();
    end

    // Single source: only req1, d1 toggling, accepted every cycle.
    doReset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] v;
      v = (i % 2 == 0) ? 4'h3 : 4'hC;
      applyStimulus(1'b0, DA, 1'b1, v, 1'b1);
      checkOutput($sformatf("single_gnt1_%0d", i), 32'(gnt1_4), 32'd1);
      tick();
      checkOutput($sformatf("single_y_%0d", i),   32'(y_4),   32'(v));
      checkOutput($sformatf("single_s_%0d", i),   32'(s_4),   32'd1);
      checkOutput($sformatf("single_vld_%0d", i), 32'(vld_4), 32'd1);
    end

    // Early release: owner 0 takes 2 beats then drops req0.
    doReset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, DA, 1'b1, D5, 1'b1);
      checkOutput($sformatf("early_gnt0_%0d", i), 32'(gnt0_4), 32'd1);
      tick();
    end
    applyStimulus(1'b0, DA, 1'b1, D5, 1'b1);
    checkOutput("early_sw_gnt0", 32'(gnt0_4), 32'd0);
    checkOutput("early_sw_gnt1", 32'(gnt1_4), 32'd1);
    tick();
    checkOutput("early_sw_y", 32'(y_4), 32'(D5));
    checkOutput("early_sw_s", 32'(s_4), 32'd1);
    // Owner 1 started at cnt=1: three more beats before source 0 wins.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, DA, 1'b1, D5, 1'b1);
      checkOutput($sformatf("early_cnt_gnt1_%0d", i), 32'(gnt1_4), 32'(i < 3));
      checkOutput($sformatf("early_cnt_gnt0_%0d", i), 32'(gnt0_4), 32'(i == 3));
      tick();
    end

    // Reset in the middle of an OWN0 burst.
    doReset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, DA, 1'b1, D5, 1'b1);
      tick();
    end
    checkOutput("mid_vld_before", 32'(vld_4), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_gnt0", 32'(gnt0_4), 32'd0);
    tick();
    checkOutput("mid_rst_vld", 32'(vld_4), 32'd0);
    checkOutput("mid_rst_y",   32'(y_4),   32'd0);
    rst = 1'b0;
    // IDLE with last=1 and cnt cleared: four source-0 beats, then source 1.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, DA, 1'b1, D5, 1'b1);
      checkOutput($sformatf("mid_after_gnt0_%0d", i), 32'(gnt0_4), 32'(i < 4));
      checkOutput($sformatf("mid_after_gnt1_%0d", i), 32'(gnt1_4), 32'(i == 4));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
